xras_reliability_scorer_mc: RTL and testbench
=============================================

// Module: xras_reliability_scorer_mc
// PURPOSE
//  Multi-channel successor of the XRAS reliability scoring stage. It takes XRAD/XENOA
//  drift samples tagged with a channel and a XENOS boundary. Per sample it emits a
//  reliability index, a boundary-weighted score, a deviation impact and a trend.
//  Each channel keeps its own history ring and running sum. The output feeds the
//  XRAS evidence/reporting path through a valid/ready handshake.
// PARAMETERS
//  NUM_CH       4    channels; each has its own history state
//  HIST_DEPTH   16   history ring depth per channel; power of two, >=2
//  SCORE_W      16   score width; MAX_SCORE must fit
//  MAX_SCORE    1000 index of a drift-free sample
//  DRIFT_SHIFT  0    penalty = drift >> DRIFT_SHIFT
//  TREND_HYST   10   dead band for the up/down trend decision
//  ALARM_THRESH 300  alarm level; used only with XRAS_SCORE_ALARM_EN
//  ALARM_COUNT  4    consecutive low samples that raise alarm (>=1)
// PORTS
//  clk             in   1        clock
//  rst             in   1        async active-high reset
//  in_valid        in   1        sample valid
//  in_ready        out  1        block can accept a sample
//  in_ch           in   $clog2(NUM_CH)  channel index
//  in_drift        in   32       unsigned drift value
//  in_boundary_id  in   16       XENOS boundary id
//  in_weight       in   8        boundary weight, Q1.7 (128 = 1.0)
//  hist_clr        in   NUM_CH   per-channel history clear, one-cycle pulse
//  out_valid       out  1        result valid
//  out_ready       in   1        downstream accepts result
//  out_ch          out  $clog2(NUM_CH)  channel of result
//  out_score       out  SCORE_W  reliability index 0..MAX_SCORE
//  out_bscore      out  SCORE_W  boundary score
//  out_impact      out  SCORE_W  drop below history reference
//  out_trend       out  2        0 down, 1 stable, 2 up
//  out_evidence    out  128      {id16, ch8, score16, drift32, impact16, ref16, trend8, cnt16}
//  alarm           out  NUM_CH   per-channel sustained low-score alarm
// BEHAVIOUR
//  - Reset: in_ready=1; out_valid=0; every data output=0 except out_trend=1.
//    All rings, sums, counts, alarm counters and alarm flags clear.
//  - FSM: IDLE -> SCORE -> REF -> OUT -> IDLE. in_ready=1 only in IDLE.
//    A sample is taken when in_valid && in_ready. out_valid rises 3 cycles after
//    acceptance and holds with stable data until out_ready. A 1-cycle IDLE follows
//    each handshake, so max throughput is one sample per 4 cycles.
//  - SCORE: pen = drift >> DRIFT_SHIFT; score = MAX_SCORE - min(pen, MAX_SCORE).
//    bscore = min((score*weight)>>7, MAX_SCORE); use a 24-bit product; saturate, never wrap.
//  - REF: reference = sum>>log2(HIST_DEPTH) when count==HIST_DEPTH, else the last
//    stored score. With count==0: impact=0, trend=1, ref=score.
//    impact = ref>score ? ref-score : 0.
//    trend = 2 if score > ref+TREND_HYST; 0 if score+TREND_HYST < ref; else 1.
//    These compares are unsigned and use no subtraction that can underflow.
//  - OUT: write score into the ring at wr_ptr[ch] and advance the pointer modulo
//    HIST_DEPTH. sum += score - oldest when full, else sum += score; count saturates
//    at HIST_DEPTH. The write happens once, when OUT is entered, not on each stall cycle.
//  - hist_clr[c] zeroes sum, count and wr_ptr of channel c the same cycle.
//    If it hits the channel being processed, the clear wins. The pending result
//    still goes out, but its ring write is dropped.
//  - in_ch >= NUM_CH: the sample is accepted and dropped, with no output.
//    The block returns to IDLE next cycle.
//  - Reset mid-operation drops any in-flight sample; outputs return to reset values at once.
// CONFIGURATION
//  XRAS_SCORE_ALARM_EN defined: per-channel low counter. It increments when
//   score < ALARM_THRESH and saturates at ALARM_COUNT; otherwise it clears.
//   alarm[c] = (cnt==ALARM_COUNT); it updates when OUT is entered; hist_clr[c] clears it.
//   The evidence cnt16 field holds the counter.
//  Undefined: alarm is tied to 0; cnt16 = history count; no alarm logic.
// TESTING
//  1 rst, then ch0 drift=0, out_ready=1 -> out_valid 3 cycles later: score=1000,
//    bscore=1000 (w=128), trend=1, impact=0.
//  2 ch1 drifts 100 then 400 -> 2nd sample: score=600, ref=900, impact=300, trend=0.
//  3 ch2: 16 samples with score 500, then drift 0 -> ref=500, trend=2, impact=0.
//    A 17th sample evicts the oldest; sum must stay exact.
//  4 drift=5000, w=255 -> score=0, bscore=0; score=1000 with w=255 -> bscore=1000 (saturated).
//  5 out_ready=0 for 10 cycles -> outputs stable, in_ready=0, exactly one ring write.
//    hist_clr[ch] during the stall -> count=0 afterwards.
//  6 ALARM_EN on: ch3 gets 4 samples with score 200 -> alarm[3]=1 after the 4th.
//    One score 800 clears it; ALARM_EN off: alarm stays 0.

Source files
------------

// File: rtl/xras_reliability_scorer_mc.sv
// Multi-channel XRAS reliability scorer: per-sample score, boundary score, impact and trend
// against a per-channel history ring. Define XRAS_SCORE_ALARM_EN for the sustained low-score alarm.
module xras_reliability_scorer_mc #(
  parameter int NUM_CH       = 4,
  parameter int HIST_DEPTH   = 16,
  parameter int SCORE_W      = 16,
  parameter int MAX_SCORE    = 1000,
  parameter int DRIFT_SHIFT  = 0,
  parameter int TREND_HYST   = 10,
  parameter int ALARM_THRESH = 300,
  parameter int ALARM_COUNT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [$clog2(NUM_CH)-1:0] in_ch,
  input  logic [31:0]               in_drift,
  input  logic [15:0]               in_boundary_id,
  input  logic [7:0]                in_weight,
  input  logic [NUM_CH-1:0]         hist_clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic [SCORE_W-1:0]        out_score,
  output logic [SCORE_W-1:0]        out_bscore,
  output logic [SCORE_W-1:0]        out_impact,
  output logic [1:0]                out_trend,
  output logic [127:0]              out_evidence,
  output logic [NUM_CH-1:0]         alarm
);
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int PTR_W  = $clog2(HIST_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SUM_W  = SCORE_W + PTR_W;
  localparam int PROD_W = SCORE_W + 8;
  localparam int SX_W   = SCORE_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCORE, S_REF, S_OUT} state_t;
  state_t state_q, state_d;

  logic ch_ok;
  assign ch_ok = 32'(in_ch) < 32'(NUM_CH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Out-of-range channels are consumed in IDLE without leaving it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid && ch_ok) state_d = S_SCORE;
      S_SCORE: state_d = S_REF;
      S_REF:   state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_OUT);
  end

  logic [CH_W-1:0]    ch_q;
  logic [31:0]        drift_q;
  logic [15:0]        id_q;
  logic [7:0]         w_q;
  logic [SCORE_W-1:0] score_q, bscore_q;
  logic [31:0]        pen;
  logic [SCORE_W-1:0] score_c, bscore_c;
  logic [PROD_W-1:0]  prod, prod_sh;

  assign pen      = drift_q >> DRIFT_SHIFT;
  assign score_c  = (pen >= 32'(MAX_SCORE)) ? '0 : SCORE_W'(32'(MAX_SCORE) - pen);
  assign prod     = PROD_W'(score_c) * PROD_W'(w_q);
  assign prod_sh  = prod >> 7;
  assign bscore_c = (prod_sh > PROD_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : SCORE_W'(prod_sh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q     <= '0;
      drift_q  <= '0;
      id_q     <= '0;
      w_q      <= '0;
      score_q  <= '0;
      bscore_q <= '0;
    end else begin
      if (state_q == S_IDLE && in_valid && ch_ok) begin
        ch_q    <= in_ch;
        drift_q <= in_drift;
        id_q    <= in_boundary_id;
        w_q     <= in_weight;
      end
      if (state_q == S_SCORE) begin
        score_q  <= score_c;
        bscore_q <= bscore_c;
      end
    end
  end

  logic [SCORE_W-1:0] ring_q [NUM_CH][HIST_DEPTH];
  logic [SUM_W-1:0]   sum_q  [NUM_CH];
  logic [CNT_W-1:0]   cnt_q  [NUM_CH];
  logic [PTR_W-1:0]   wp_q   [NUM_CH];

  logic               full_c;
  logic [SCORE_W-1:0] ref_c, impact_c, oldest_c;
  logic [1:0]         trend_c;
  logic [CNT_W-1:0]   cnt_new_c;
  logic [SX_W-1:0]    score_x, ref_x;

  // Trend compares are widened by one bit so adding the dead band cannot wrap.
  always_comb begin
    full_c   = (cnt_q[ch_q] == CNT_W'(HIST_DEPTH));
    oldest_c = ring_q[ch_q][wp_q[ch_q]];
    if (cnt_q[ch_q] == '0) ref_c = score_q;
    else if (full_c)       ref_c = SCORE_W'(sum_q[ch_q] >> PTR_W);
    else                   ref_c = ring_q[ch_q][wp_q[ch_q] - PTR_W'(1)];
    impact_c = (ref_c > score_q) ? ref_c - score_q : '0;
    score_x  = {1'b0, score_q};
    ref_x    = {1'b0, ref_c};
    if (score_x > ref_x + SX_W'(TREND_HYST))      trend_c = 2'd2;
    else if (score_x + SX_W'(TREND_HYST) < ref_x) trend_c = 2'd0;
    else                                          trend_c = 2'd1;
    if (hist_clr[ch_q]) cnt_new_c = '0;
    else if (full_c)    cnt_new_c = cnt_q[ch_q];
    else                cnt_new_c = cnt_q[ch_q] + CNT_W'(1);
  end

  // History is committed on the REF->OUT edge only; a same-cycle clear discards it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sum_q[c] <= '0;
        cnt_q[c] <= '0;
        wp_q[c]  <= '0;
        for (int i = 0; i < HIST_DEPTH; i++) ring_q[c][i] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (hist_clr[c]) begin
          sum_q[c] <= '0;
          cnt_q[c] <= '0;
          wp_q[c]  <= '0;
        end else if (state_q == S_REF && ch_q == CH_W'(c)) begin
          ring_q[c][wp_q[c]] <= score_q;
          wp_q[c]  <= wp_q[c] + PTR_W'(1);
          cnt_q[c] <= cnt_new_c;
          sum_q[c] <= full_c ? sum_q[c] - SUM_W'(oldest_c) + SUM_W'(score_q)
                             : sum_q[c] + SUM_W'(score_q);
        end
      end
    end
  end

  logic [15:0] ev_cnt;
`ifdef XRAS_SCORE_ALARM_EN
  localparam int AC_W = $clog2(ALARM_COUNT + 1);
  logic [AC_W-1:0]   acnt_q [NUM_CH];
  logic [AC_W-1:0]   acnt_new_c;
  logic [NUM_CH-1:0] alarm_q;

  always_comb begin
    if (score_q >= SCORE_W'(ALARM_THRESH))          acnt_new_c = '0;
    else if (acnt_q[ch_q] == AC_W'(ALARM_COUNT))    acnt_new_c = acnt_q[ch_q];
    else                                            acnt_new_c = acnt_q[ch_q] + AC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q <= '0;
      for (int c = 0; c < NUM_CH; c++) acnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (hist_clr[c]) begin
          acnt_q[c]  <= '0;
          alarm_q[c] <= 1'b0;
        end else if (state_q == S_REF && ch_q == CH_W'(c)) begin
          acnt_q[c]  <= acnt_new_c;
          alarm_q[c] <= (acnt_new_c == AC_W'(ALARM_COUNT));
        end
      end
    end
  end

  assign alarm  = alarm_q;
  assign ev_cnt = hist_clr[ch_q] ? 16'd0 : 16'(acnt_new_c);
`else
  assign alarm  = '0;
  assign ev_cnt = 16'(cnt_new_c);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_ch       <= '0;
      out_score    <= '0;
      out_bscore   <= '0;
      out_impact   <= '0;
      out_trend    <= 2'd1;
      out_evidence <= '0;
    end else if (state_q == S_REF) begin
      out_ch       <= ch_q;
      out_score    <= score_q;
      out_bscore   <= bscore_q;
      out_impact   <= impact_c;
      out_trend    <= trend_c;
      out_evidence <= {id_q, 8'(ch_q), 16'(score_q), drift_q, 16'(impact_c),
                       16'(ref_c), 8'(trend_c), ev_cnt};
    end
  end

endmodule

// File: tb/tb_xras_reliability_scorer_mc.sv
// Bench for xras_reliability_scorer_mc: directed scenarios and randomized traffic
// compared against a queue-based per-channel history model.
module tb_xras_reliability_scorer_mc;
  localparam int NUM_CH       = 4;
  localparam int HIST_DEPTH   = 16;
  localparam int MAX_SCORE    = 1000;
  localparam int DRIFT_SHIFT  = 0;
  localparam int TREND_HYST   = 10;
  localparam int ALARM_THRESH = 300;
  localparam int ALARM_COUNT  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_ch;
  logic [31:0]       in_drift;
  logic [15:0]       in_boundary_id;
  logic [7:0]        in_weight;
  logic [NUM_CH-1:0] hist_clr;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_ch;
  logic [15:0]       out_score, out_bscore, out_impact;
  logic [1:0]        out_trend;
  logic [127:0]      out_evidence;
  logic [NUM_CH-1:0] alarm;

  always #5 clk = ~clk;

  xras_reliability_scorer_mc #(
    .NUM_CH(NUM_CH), .HIST_DEPTH(HIST_DEPTH), .SCORE_W(16), .MAX_SCORE(MAX_SCORE),
    .DRIFT_SHIFT(DRIFT_SHIFT), .TREND_HYST(TREND_HYST), .ALARM_THRESH(ALARM_THRESH),
    .ALARM_COUNT(ALARM_COUNT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_drift(in_drift), .in_boundary_id(in_boundary_id), .in_weight(in_weight),
    .hist_clr(hist_clr), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_score(out_score), .out_bscore(out_bscore), .out_impact(out_impact),
    .out_trend(out_trend), .out_evidence(out_evidence), .alarm(alarm)
  );

  int checks = 0;
  int errors = 0;

  int hist [NUM_CH][$];
  int acnt [NUM_CH];
  int e_sc, e_bsc, e_imp, e_ref, e_tr, e_cnt;

  function automatic void model_clear(input int c);
    hist[c].delete();
    acnt[c] = 0;
  endfunction

  function automatic void model_sample(input int c, input logic [31:0] drift, input int w);
    longint pen;
    int sum;
    pen   = longint'(drift) >> DRIFT_SHIFT;
    e_sc  = (pen >= MAX_SCORE) ? 0 : MAX_SCORE - int'(pen);
    e_bsc = (e_sc * w) / 128;
    if (e_bsc > MAX_SCORE) e_bsc = MAX_SCORE;
    if (hist[c].size() == 0) e_ref = e_sc;
    else if (hist[c].size() == HIST_DEPTH) begin
      sum = 0;
      for (int i = 0; i < hist[c].size(); i++) sum += hist[c][i];
      e_ref = sum / HIST_DEPTH;
    end else e_ref = hist[c][hist[c].size()-1];
    e_imp = (e_ref > e_sc) ? e_ref - e_sc : 0;
    if (e_sc > e_ref + TREND_HYST)      e_tr = 2;
    else if (e_sc + TREND_HYST < e_ref) e_tr = 0;
    else                                e_tr = 1;
    hist[c].push_back(e_sc);
    if (hist[c].size() > HIST_DEPTH) void'(hist[c].pop_front());
    if (e_sc < ALARM_THRESH) acnt[c] = (acnt[c] < ALARM_COUNT) ? acnt[c] + 1 : ALARM_COUNT;
    else                     acnt[c] = 0;
`ifdef XRAS_SCORE_ALARM_EN
    e_cnt = acnt[c];
`else
    e_cnt = hist[c].size();
`endif
  endfunction

  function automatic logic [NUM_CH-1:0] exp_alarm();
    logic [NUM_CH-1:0] v;
    v = '0;
`ifdef XRAS_SCORE_ALARM_EN
    for (int c = 0; c < NUM_CH; c++) v[c] = (acnt[c] == ALARM_COUNT);
`endif
    return v;
  endfunction

  // One sample end to end; stall holds out_ready low, clr_ch pulses a clear mid-stall.
  task automatic send(input string tag, input int c, input logic [31:0] drift, input int w,
                      input logic [15:0] id, input int stall, input int clr_ch);
    int waited, lat;
    logic [127:0] ev;
    logic [NUM_CH-1:0] al;
    waited = 0;
    while (!in_ready && waited < 20) begin @(posedge clk); #1; waited++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s idle_wait: in_ready=%b expected 1", tag, in_ready); end
    model_sample(c, drift, w);
    ev = {id, 8'(c), 16'(e_sc), drift, 16'(e_imp), 16'(e_ref), 8'(e_tr), 16'(e_cnt)};
    al = exp_alarm();
    in_valid = 1'b1; in_ch = 2'(c); in_drift = drift; in_weight = 8'(w); in_boundary_id = id;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL %s busy: in_ready=%b expected 0", tag, in_ready); end
    lat = 0;
    while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL %s latency: got %0d edges expected 2", tag, lat); end
    checks++;
    if (out_ch !== 2'(c)) begin errors++; $display("FAIL %s ch: got %0d expected %0d", tag, out_ch, c); end
    checks++;
    if (out_score !== 16'(e_sc)) begin errors++; $display("FAIL %s score: got %0d expected %0d", tag, out_score, e_sc); end
    checks++;
    if (out_bscore !== 16'(e_bsc)) begin errors++; $display("FAIL %s bscore: got %0d expected %0d", tag, out_bscore, e_bsc); end
    checks++;
    if (out_impact !== 16'(e_imp)) begin errors++; $display("FAIL %s impact: got %0d expected %0d", tag, out_impact, e_imp); end
    checks++;
    if (out_trend !== 2'(e_tr)) begin errors++; $display("FAIL %s trend: got %0d expected %0d", tag, out_trend, e_tr); end
    checks++;
    if (out_evidence !== ev) begin errors++; $display("FAIL %s evidence: got %h expected %h", tag, out_evidence, ev); end
    checks++;
    if (alarm !== al) begin errors++; $display("FAIL %s alarm: got %b expected %b", tag, alarm, al); end
    for (int s = 0; s < stall; s++) begin
      if (clr_ch >= 0 && s == stall / 2) hist_clr[clr_ch] = 1'b1;
      @(posedge clk); #1;
      if (hist_clr != '0) begin hist_clr = '0; model_clear(clr_ch); end
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_score !== 16'(e_sc) || out_evidence !== ev) begin
        errors++;
        $display("FAIL %s stall_hold: valid=%b ready=%b score=%0d expected valid=1 ready=0 score=%0d", tag,
                 out_valid, in_ready, out_score, e_sc);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s handshake: valid=%b ready=%b expected 0/1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_drift = '0; in_boundary_id = '0;
    in_weight = '0; hist_clr = '0; out_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) model_clear(c);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    checks++;
    if (out_score !== 0 || out_bscore !== 0 || out_impact !== 0 || out_ch !== 0) begin
      errors++; $display("FAIL reset_data: score=%0d bscore=%0d impact=%0d expected 0", out_score, out_bscore, out_impact);
    end
    checks++;
    if (out_trend !== 2'd1 || out_evidence !== '0 || alarm !== '0) begin
      errors++; $display("FAIL reset_misc: trend=%0d evidence=%h alarm=%b expected 1/0/0", out_trend, out_evidence, alarm);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send("basic", 0, 32'd0, 128, 16'h1001, 0, -1);
    checks++;
    if (out_score !== 16'd1000 || out_bscore !== 16'd1000) begin
      errors++; $display("FAIL basic_const: score=%0d bscore=%0d expected 1000/1000", out_score, out_bscore);
    end
  endtask

  task automatic test_trend_down();
    send("down_a", 1, 32'd100, 128, 16'h2001, 0, -1);
    send("down_b", 1, 32'd400, 128, 16'h2002, 0, -1);
    checks++;
    if (out_impact !== 16'd300 || out_trend !== 2'd0) begin
      errors++; $display("FAIL down_const: impact=%0d trend=%0d expected 300/0", out_impact, out_trend);
    end
  endtask

  task automatic test_full_ring();
    for (int i = 0; i < HIST_DEPTH; i++) send("fill", 2, 32'd500, 128, 16'(16'h3000 + i), 0, -1);
    send("full_up", 2, 32'd0, 128, 16'h3100, 0, -1);
    checks++;
    if (out_trend !== 2'd2 || out_impact !== 16'd0) begin
      errors++; $display("FAIL full_const: trend=%0d impact=%0d expected 2/0", out_trend, out_impact);
    end
    send("evict", 2, 32'd20, 128, 16'h3101, 0, -1);
    send("evict2", 2, 32'd700, 64, 16'h3102, 0, -1);
  endtask

  task automatic test_saturate();
    send("sat_zero", 0, 32'd5000, 255, 16'h4001, 0, -1);
    send("sat_max", 0, 32'd0, 255, 16'h4002, 0, -1);
    checks++;
    if (out_bscore !== 16'd1000) begin
      errors++; $display("FAIL sat_const: bscore=%0d expected 1000", out_bscore);
    end
  endtask

  task automatic test_stall();
    send("stall", 0, 32'd123, 100, 16'h5001, 10, -1);
    send("after_stall", 0, 32'd130, 100, 16'h5002, 0, -1);
    send("stall_clr", 1, 32'd250, 128, 16'h5003, 10, 1);
    send("after_clr", 1, 32'd600, 128, 16'h5004, 0, -1);
  endtask

  task automatic test_alarm();
    @(posedge clk); #1;
    hist_clr = 4'b1000;
    @(posedge clk); #1;
    hist_clr = '0;
    model_clear(3);
    for (int i = 0; i < ALARM_COUNT; i++) send("alarm_low", 3, 32'd800, 128, 16'(16'h6000 + i), 0, -1);
    checks++;
`ifdef XRAS_SCORE_ALARM_EN
    if (alarm[3] !== 1'b1) begin errors++; $display("FAIL alarm_set: alarm3=%b expected 1", alarm[3]); end
`else
    if (alarm[3] !== 1'b0) begin errors++; $display("FAIL alarm_set: alarm3=%b expected 0", alarm[3]); end
`endif
    send("alarm_clear", 3, 32'd200, 128, 16'h6100, 0, -1);
    checks++;
    if (alarm[3] !== 1'b0) begin errors++; $display("FAIL alarm_clr: alarm3=%b expected 0", alarm[3]); end
  endtask

  task automatic test_back_to_back();
    int acc;
    logic [127:0] ev;
    acc = 0;
    in_valid = 1'b1; in_ch = 2'd1; in_drift = 32'd50; in_weight = 8'd128;
    in_boundary_id = 16'h7777; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) model_sample(1, 32'd50, 128);
    ev = {16'h7777, 8'd1, 16'(e_sc), 32'd50, 16'(e_imp), 16'(e_ref), 8'(e_tr), 16'(e_cnt)};
    checks++;
    if (acc != 4) begin errors++; $display("FAIL b2b_rate: accepts=%0d expected 4", acc); end
    checks++;
    if (out_score !== 16'(e_sc) || out_evidence !== ev) begin
      errors++; $display("FAIL b2b_last: score=%0d evidence=%h expected %0d %h", out_score, out_evidence, e_sc, ev);
    end
  endtask

  task automatic test_random();
    int c, sel, stall, clr;
    logic [31:0] drift;
    for (int n = 0; n < 80; n++) begin
      c = $urandom_range(0, NUM_CH - 1);
      sel = $urandom_range(0, 9);
      if (sel < 6)      drift = $urandom_range(0, 1100);
      else if (sel < 8) drift = $urandom_range(0, 40);
      else              drift = $urandom;
      stall = $urandom_range(0, 2);
      clr = (stall > 0 && $urandom_range(0, 9) == 0) ? c : -1;
      send("rand", c, drift, $urandom_range(0, 255), 16'($urandom), stall, clr);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_ch = 2'd2; in_drift = 32'd0; in_weight = 8'd128; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_trend !== 2'd1 || out_score !== 0 || out_evidence !== '0) begin
      errors++; $display("FAIL reset_mid: valid=%b ready=%b trend=%0d score=%0d expected 0/1/1/0",
                         out_valid, in_ready, out_trend, out_score);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) model_clear(c);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_drop: out_valid=%b expected 0", out_valid); end
    send("post_reset", 2, 32'd100, 128, 16'h8001, 0, -1);
    send("post_reset2", 2, 32'd300, 128, 16'h8002, 0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trend_down();
    test_full_ring();
    test_saturate();
    test_stall();
    test_alarm();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
